// File: rtl/ram_256x64_pkg.sv
// ============================================================================
// Module : ram_256x64_pkg
// Brief  : Shared defaults and access-operation encoding for ram_256x64.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ram_256x64_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned DATA_WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } ram_op_e;

  // cen gates everything; wen only selects direction once enabled
  function automatic ram_op_e decode_op(input logic cen, input logic wen);
    ram_op_e op;
    op = OP_IDLE;
    if (cen) begin
      op = wen ? OP_WRITE : OP_READ;
    end
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_256x64_ram_word_array.sv
// ============================================================================
// Module : ram_word_array
// Brief  : Storage array with asynchronous clear and one synchronous write port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram_word_array
  import ram_256x64_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Combinational read of current contents; the top registers it
  assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/ram_256x64.sv
// ============================================================================
// Module : ram_256x64
// Brief  : Single-port 256x64 synchronous RAM with registered read data.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram_256x64
  import ram_256x64_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cen,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [DATA_WIDTH-1:0] s_din,
  output logic [DATA_WIDTH-1:0] s_dout
);

  ram_op_e               op;
  logic                  we;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] s_dout_d;
  logic [DATA_WIDTH-1:0] s_dout_q;

  assign op = decode_op(cen, wen);
  assign we = (op == OP_WRITE);

  ram_word_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (we),
    .addr_i  (s_addr),
    .wdata_i (s_din),
    .rdata_o (rdata)
  );

  // Only a read returns data; idle and write cycles drive zero
  always_comb begin
    s_dout_d = '0;
    if (op == OP_READ) begin
      s_dout_d = rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_dout_q <= '0;
    end else begin
      s_dout_q <= s_dout_d;
    end
  end

  assign s_dout = s_dout_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_256x64.sv
// ============================================================================
// Module : tb_ram_256x64
// Brief  : Directed self-checking bench for ram_256x64.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ram_256x64;

  logic        clk;
  logic        reset_n;
  logic        cen;
  logic        wen;
  logic [7:0]  s_addr;
  logic [63:0] s_din;
  logic [63:0] s_dout;

  int checks;
  int errors;

  localparam logic [63:0] D01 = 64'hABCD_0000_0000_ABCD;
  localparam logic [63:0] D02 = 64'h1234_0000_0000_1234;
  localparam logic [63:0] DAB = 64'hFFFF_0000_0814_FFFF;
  localparam logic [63:0] D00 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DFF = 64'hFEDC_BA98_7654_3210;

  ram_256x64 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cen     (cen),
    .wen     (wen),
    .s_addr  (s_addr),
    .s_din   (s_din),
    .s_dout  (s_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one access at the negedge, then step just past the next rising edge
  task automatic access(input logic c, input logic w, input logic [7:0] a, input logic [63:0] d);
    @(negedge clk);
    cen    = c;
    wen    = w;
    s_addr = a;
    s_din  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    cen     = 1'b0;
    wen     = 1'b0;
    s_addr  = 8'h00;
    s_din   = 64'h0;

    #1;
    chk("reset_dout_async", s_dout, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout_held", s_dout, 64'h0);

    @(negedge clk);
    reset_n = 1'b1;

    access(1'b1, 1'b0, 8'h01, 64'h0);
    chk("post_reset_rd01", s_dout, 64'h0);
    access(1'b1, 1'b0, 8'h02, 64'h0);
    chk("post_reset_rd02", s_dout, 64'h0);
    access(1'b1, 1'b0, 8'hAB, 64'h0);
    chk("post_reset_rdAB", s_dout, 64'h0);

    access(1'b1, 1'b1, 8'h01, D01);
    chk("wr01_dout", s_dout, 64'h0);
    access(1'b1, 1'b1, 8'h02, D02);
    chk("wr02_dout", s_dout, 64'h0);
    access(1'b1, 1'b1, 8'hAB, DAB);
    chk("wrAB_dout", s_dout, 64'h0);

    access(1'b1, 1'b0, 8'h01, 64'h0);
    chk("rd01", s_dout, D01);
    access(1'b1, 1'b0, 8'h02, 64'h0);
    chk("rd02", s_dout, D02);
    access(1'b1, 1'b0, 8'hAB, 64'h0);
    chk("rdAB", s_dout, DAB);
    @(negedge clk);
    chk("rdAB_hold", s_dout, DAB);

    // write cycle right after a read must clear the output
    access(1'b1, 1'b1, 8'h02, D02);
    chk("wr_after_rd_dout", s_dout, 64'h0);

    access(1'b0, 1'b1, 8'h01, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("cen0_dout", s_dout, 64'h0);
    access(1'b1, 1'b0, 8'h01, 64'h0);
    chk("cen0_no_write", s_dout, D01);
    access(1'b0, 1'b0, 8'h01, 64'h0);
    chk("idle_dout", s_dout, 64'h0);

    access(1'b1, 1'b1, 8'h00, D00);
    access(1'b1, 1'b1, 8'hFF, DFF);
    access(1'b1, 1'b0, 8'h00, 64'h0);
    chk("rd00", s_dout, D00);
    access(1'b1, 1'b0, 8'hFF, 64'h0);
    chk("rdFF", s_dout, DFF);
    access(1'b1, 1'b0, 8'h01, 64'h0);
    chk("rd01_no_alias", s_dout, D01);
    access(1'b1, 1'b0, 8'hAB, 64'h0);
    chk("rdAB_no_alias", s_dout, DAB);

    // asynchronous reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_dout", s_dout, 64'h0);
    @(negedge clk);
    cen     = 1'b0;
    wen     = 1'b0;
    reset_n = 1'b1;
    access(1'b1, 1'b0, 8'hAB, 64'h0);
    chk("rdAB_after_reset", s_dout, 64'h0);
    access(1'b1, 1'b0, 8'hFF, 64'h0);
    chk("rdFF_after_reset", s_dout, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
